mdu: RTL



---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the md_op encodings, the FSM state type and the default latencies.
package mdu_pkg;

  localparam int DefMultCycles = 5;
  localparam int DefDivCycles  = 10;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO register pair.
// The result is computed at issue into pending registers and only becomes
// architecturally visible in HI/LO after the fixed latency has elapsed, so the
// hazard unit can stall on busy.
// Optional macro MDU_DIV0_GUARD_EN: when defined, div/divu with a zero divisor
// are not started and leave HI/LO untouched; otherwise they run the full divide
// latency and commit HI=a, LO=all ones.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DefMultCycles,
  parameter int DIV_CYCLES  = DefDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       pendHi_q, pendHi_d;
  logic [31:0]       pendLo_q, pendLo_d;

  logic [63:0]        prodS;
  logic [63:0]        prodU;
  logic signed [32:0] divA;
  logic signed [32:0] divB;
  logic signed [32:0] quotS;
  logic signed [32:0] remS;
  logic [31:0]        quotU;
  logic [31:0]        remU;
  logic               divByZero;
  logic               unusedBits;

  logic [31:0]     resHi;
  logic [31:0]     resLo;
  logic [CntW-1:0] opLat;
  logic            issueOk;

  // 33-bit sign extension keeps 0x80000000 / -1 representable (+2^31), whose
  // low 32 bits give the architecturally expected 0x80000000 quotient.
  assign divA      = $signed({a[31], a});
  assign divB      = $signed({b[31], b});
  assign divByZero = (b == 32'd0);
  assign prodS     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodU     = {32'd0, a} * {32'd0, b};
  assign quotS     = divByZero ? 33'sd0 : (divA / divB);
  assign remS      = divByZero ? 33'sd0 : (divA % divB);
  assign quotU     = divByZero ? 32'd0 : (a / b);
  assign remU      = divByZero ? 32'd0 : (a % b);
  assign unusedBits = quotS[32] ^ remS[32];

  // Select the result and latency of a multiply/divide issued this cycle.
  always_comb begin
    resHi   = 32'd0;
    resLo   = 32'd0;
    opLat   = CntW'(MULT_CYCLES);
    issueOk = 1'b0;
    case (md_op)
      OP_MULT: begin
        {resHi, resLo} = prodS;
        issueOk        = 1'b1;
      end
      OP_MULTU: begin
        {resHi, resLo} = prodU;
        issueOk        = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        opLat = CntW'(DIV_CYCLES);
        if (divByZero) begin
`ifdef MDU_DIV0_GUARD_EN
          issueOk = 1'b0;
`else
          resHi   = a;
          resLo   = 32'hFFFF_FFFF;
          issueOk = 1'b1;
`endif
        end else if (md_op == OP_DIV) begin
          resHi   = remS[31:0];
          resLo   = quotS[31:0];
          issueOk = 1'b1;
        end else begin
          resHi   = remU;
          resLo   = quotU;
          issueOk = 1'b1;
        end
      end
      default: issueOk = 1'b0;
    endcase
  end

  // Next-state logic: issue or move-to in IDLE, count down and commit in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (issueOk) begin
            pendHi_d = resHi;
            pendLo_d = resLo;
            cnt_d    = opLat;
            state_d  = ST_RUN;
          end else if (md_op == OP_MTHI) begin
            hi_d = a;
          end else if (md_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CntW'(1)) begin
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pendHi_q <= 32'd0;
      pendLo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
